// File: rtl/adjust_mode_ctrl.sv
// RUN/EDIT mode controller: field selection, registered adjust pulses, inactivity timeout.
// Optional auto-repeat on held up/down levels is enabled by defining AUTO_REPEAT_EN.
`timescale 1ns/1ps
module adjust_mode_ctrl #(
  parameter int NUM_FIELDS    = 4,
  parameter int IDX_W         = 2,
  parameter int TIMEOUT_TICKS = 2000,
  parameter int REPEAT_DELAY  = 100,
  parameter int REPEAT_RATE   = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick_en,
  input  logic                  btn_c,
  input  logic                  btn_r,
  input  logic                  btn_l,
  input  logic                  btn_u,
  input  logic                  btn_d,
  input  logic                  btn_u_lvl,
  input  logic                  btn_d_lvl,
  output logic                  run_en,
  output logic                  edit_mode,
  output logic [IDX_W-1:0]      field_sel,
  output logic [NUM_FIELDS-1:0] field_onehot,
  output logic                  adj_en,
  output logic                  adj_dir,
  output logic                  timeout_evt
);

  localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_TICKS - 1);
  localparam logic [IDX_W-1:0] SEL_LAST = IDX_W'(NUM_FIELDS - 1);

  typedef enum logic {RUN, EDIT} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        sel_q, sel_d;
  logic [NUM_FIELDS-1:0]   onehot_q, onehot_d;
  logic                    adj_en_q, adj_en_d;
  logic                    adj_dir_q, adj_dir_d;
  logic                    to_evt_q, to_evt_d;
  logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
  logic                    lvl_hold;
  logic                    rep_fire;
  logic                    rep_dir;

  assign lvl_hold = btn_u_lvl | btn_d_lvl;

`ifdef AUTO_REPEAT_EN
  localparam int RP_W = $clog2(REPEAT_DELAY + 1);
  localparam logic [RP_W-1:0] RP_LAST   = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] RP_RELOAD =
    RP_W'((REPEAT_RATE >= REPEAT_DELAY) ? 0 : (REPEAT_DELAY - REPEAT_RATE));

  logic [RP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic            rep_active;

  // Counter reloads to DELAY-RATE after each fire so later pulses come every RATE ticks
  assign rep_active = (state_q == EDIT) && (btn_u_lvl ^ btn_d_lvl) && !(btn_c | btn_r | btn_l);
  assign rep_dir    = btn_u_lvl;

  always_comb begin
    rep_cnt_d = '0;
    rep_fire  = 1'b0;
    if (rep_active) begin
      rep_cnt_d = rep_cnt_q;
      if (tick_en) begin
        if (rep_cnt_q >= RP_LAST) begin
          rep_fire  = 1'b1;
          rep_cnt_d = RP_RELOAD;
        end else begin
          rep_cnt_d = rep_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rep_cnt_q <= '0;
    else     rep_cnt_q <= rep_cnt_d;
  end
`else
  assign rep_fire = 1'b0;
  assign rep_dir  = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    adj_en_d  = 1'b0;
    adj_dir_d = adj_dir_q;
    to_evt_d  = 1'b0;
    to_cnt_d  = to_cnt_q;
    unique case (state_q)
      RUN: begin
        to_cnt_d = '0;
        if (btn_c) begin
          state_d = EDIT;
          sel_d   = '0;
        end
      end
      EDIT: begin
        if (btn_c) begin
          state_d  = RUN;
          sel_d    = '0;
          to_cnt_d = '0;
        end else if (btn_r) begin
          sel_d    = (sel_q >= SEL_LAST) ? '0 : sel_q + 1'b1;
          to_cnt_d = '0;
        end else if (btn_l) begin
          sel_d    = (sel_q == '0) ? SEL_LAST : sel_q - 1'b1;
          to_cnt_d = '0;
        end else if (btn_u) begin
          adj_en_d  = 1'b1;
          adj_dir_d = 1'b1;
          to_cnt_d  = '0;
        end else if (btn_d) begin
          adj_en_d  = 1'b1;
          adj_dir_d = 1'b0;
          to_cnt_d  = '0;
        end else if (lvl_hold) begin
          to_cnt_d = '0;
          if (rep_fire) begin
            adj_en_d  = 1'b1;
            adj_dir_d = rep_dir;
          end
        end else if (tick_en) begin
          if (to_cnt_q >= TO_LAST) begin
            state_d  = RUN;
            sel_d    = '0;
            to_evt_d = 1'b1;
            to_cnt_d = '0;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = RUN;
    endcase

    onehot_d = '0;
    for (int i = 0; i < NUM_FIELDS; i++)
      onehot_d[i] = (state_d == EDIT) && (sel_d == IDX_W'(i));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      sel_q     <= '0;
      onehot_q  <= '0;
      adj_en_q  <= 1'b0;
      adj_dir_q <= 1'b1;
      to_evt_q  <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      onehot_q  <= onehot_d;
      adj_en_q  <= adj_en_d;
      adj_dir_q <= adj_dir_d;
      to_evt_q  <= to_evt_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  assign run_en       = (state_q == RUN);
  assign edit_mode    = (state_q == EDIT);
  assign field_sel    = sel_q;
  assign field_onehot = onehot_q;
  assign adj_en       = adj_en_q;
  assign adj_dir      = adj_dir_q;
  assign timeout_evt  = to_evt_q;

endmodule

// File: tb/tb_adjust_mode_ctrl.sv
// Directed bench for adjust_mode_ctrl: a 4-field instance and a 1-field instance share stimulus.
`timescale 1ns/1ps
module tb_adjust_mode_ctrl;

`ifdef AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick_en = 0, btn_c = 0, btn_r = 0, btn_l = 0, btn_u = 0, btn_d = 0;
  logic btn_u_lvl = 0, btn_d_lvl = 0;

  logic       run_en, edit_mode, adj_en, adj_dir, timeout_evt;
  logic [1:0] field_sel;
  logic [3:0] field_onehot;
  logic       run_en1, edit_mode1, adj_en1, adj_dir1, timeout_evt1;
  logic [0:0] field_sel1;
  logic [0:0] field_onehot1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  adjust_mode_ctrl #(.NUM_FIELDS(4), .IDX_W(2), .TIMEOUT_TICKS(5),
                     .REPEAT_DELAY(4), .REPEAT_RATE(2)) dut (
    .clk(clk), .rst(rst), .tick_en(tick_en),
    .btn_c(btn_c), .btn_r(btn_r), .btn_l(btn_l), .btn_u(btn_u), .btn_d(btn_d),
    .btn_u_lvl(btn_u_lvl), .btn_d_lvl(btn_d_lvl),
    .run_en(run_en), .edit_mode(edit_mode), .field_sel(field_sel),
    .field_onehot(field_onehot), .adj_en(adj_en), .adj_dir(adj_dir),
    .timeout_evt(timeout_evt));

  adjust_mode_ctrl #(.NUM_FIELDS(1), .IDX_W(1), .TIMEOUT_TICKS(5),
                     .REPEAT_DELAY(4), .REPEAT_RATE(2)) dut1 (
    .clk(clk), .rst(rst), .tick_en(tick_en),
    .btn_c(btn_c), .btn_r(btn_r), .btn_l(btn_l), .btn_u(btn_u), .btn_d(btn_d),
    .btn_u_lvl(btn_u_lvl), .btn_d_lvl(btn_d_lvl),
    .run_en(run_en1), .edit_mode(edit_mode1), .field_sel(field_sel1),
    .field_onehot(field_onehot1), .adj_en(adj_en1), .adj_dir(adj_dir1),
    .timeout_evt(timeout_evt1));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_btns();
    tick_en = 0; btn_c = 0; btn_r = 0; btn_l = 0; btn_u = 0; btn_d = 0;
  endtask

  task automatic tick();
    tick_en = 1;
    step();
    clear_btns();
  endtask

  initial begin
    bit exp_fire;
    // reset state
    step(); step();
    check_val("rst_run_en", run_en, 1);
    check_val("rst_edit", edit_mode, 0);
    check_val("rst_onehot", field_onehot, 4'b0000);
    check_val("rst_adj_en", adj_en, 0);
    check_val("rst_adj_dir", adj_dir, 1);
    check_val("rst_tevt", timeout_evt, 0);
    rst = 0;
    step();
    btn_u = 1; step(); clear_btns();
    check_val("run_ignore_u", adj_en, 0);

    // enter EDIT
    btn_c = 1; step(); clear_btns();
    check_val("edit_mode", edit_mode, 1);
    check_val("edit_run_en", run_en, 0);
    check_val("edit_onehot", field_onehot, 4'b0001);
    check_val("f1_onehot", field_onehot1, 1'b1);

    // field wrap
    btn_l = 1; step(); clear_btns();
    check_val("l_wrap_sel", field_sel, 3);
    check_val("l_wrap_onehot", field_onehot, 4'b1000);
    check_val("f1_l_sel", field_sel1, 0);
    btn_r = 1; step(); clear_btns();
    check_val("r_wrap_sel", field_sel, 0);
    check_val("f1_r_sel", field_sel1, 0);
    for (int i = 0; i < 3; i++) begin
      btn_r = 1; step(); clear_btns();
    end
    check_val("r_x4_sel", field_sel, 3);

    // adjust pulses
    btn_u = 1; step(); clear_btns();
    check_val("u_adj_en", adj_en, 1);
    check_val("u_adj_dir", adj_dir, 1);
    step();
    check_val("u_adj_en_once", adj_en, 0);
    btn_d = 1; step(); clear_btns();
    check_val("d_adj_en", adj_en, 1);
    check_val("d_adj_dir", adj_dir, 0);
    btn_u = 1; btn_d = 1; step(); clear_btns();
    check_val("ud_adj_en", adj_en, 1);
    check_val("ud_adj_dir", adj_dir, 1);
    btn_c = 1; btn_u = 1; step(); clear_btns();
    check_val("cu_run_en", run_en, 1);
    check_val("cu_adj_en", adj_en, 0);
    check_val("cu_onehot", field_onehot, 4'b0000);

    // timeout, restarted by btn_r on 4th tick
    btn_c = 1; step(); clear_btns();
    for (int i = 0; i < 3; i++) begin tick(); step(); end
    btn_r = 1; tick(); step();
    check_val("to_restart_edit", edit_mode, 1);
    check_val("to_restart_sel", field_sel, 1);
    for (int i = 0; i < 4; i++) begin tick(); step(); end
    check_val("to_4_edit", edit_mode, 1);
    check_val("to_4_evt", timeout_evt, 0);
    tick();
    check_val("to_5_evt", timeout_evt, 1);
    check_val("to_5_run_en", run_en, 1);
    check_val("to_5_onehot", field_onehot, 4'b0000);
    step();
    check_val("to_evt_once", timeout_evt, 0);

    // held up level: auto-repeat (when built in), no timeout
    btn_c = 1; step(); clear_btns();
    btn_u = 1; btn_u_lvl = 1; step(); clear_btns();
    check_val("hold_first_adj", adj_en, 1);
    for (int k = 1; k <= 10; k++) begin
      exp_fire = AR && (k >= 4) && (k % 2 == 0);
      tick();
      check_val($sformatf("rep_tick%0d_adj", k), adj_en, exp_fire);
      if (exp_fire) check_val($sformatf("rep_tick%0d_dir", k), adj_dir, 1);
      step();
      check_val($sformatf("rep_gap%0d_adj", k), adj_en, 0);
    end
    check_val("hold_no_timeout", edit_mode, 1);
    btn_u_lvl = 0;

    // async reset mid-EDIT clears a pending adjust pulse
    btn_r = 1; step(); clear_btns();
    btn_u = 1; step(); clear_btns();
    check_val("pre_rst_adj", adj_en, 1);
    rst = 1; #1;
    check_val("arst_adj_en", adj_en, 0);
    check_val("arst_run_en", run_en, 1);
    check_val("arst_sel", field_sel, 0);
    check_val("arst_onehot", field_onehot, 4'b0000);
    step();
    rst = 0;
    step();
    check_val("post_rst_run", run_en, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
